paddle_ctrl: RTL and testbench

Upstream stage of the ball state machine. Converts the four raw player push-buttons into the 10-bit paddle-centre positions p1_position and p2_position, which the ball logic and the VGA renderer consume. Movement happens on a slow internal move tick. Holding a button accelerates the paddle. The block also freezes the paddles when the game is over.

---
 rtl/paddle_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_paddle_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/paddle_ctrl.sv
// Paddle controller: synchronizes the four player buttons and moves two paddle centres on a slow
// move tick, with hold-to-accelerate. Optional macro PADDLE_AUTO_P2_EN makes paddle 2 follow ball_y.
module paddle_ctrl #(
    parameter int TICK_DIV   = 500000,
    parameter int POS_INIT   = 245,
    parameter int POS_MIN    = 50,
    parameter int POS_MAX    = 430,
    parameter int STEP_SLOW  = 2,
    parameter int STEP_FAST  = 6,
    parameter int HOLD_TICKS = 16
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       p1_up,
    input  logic       p1_down,
    input  logic       p2_up,
    input  logic       p2_down,
    input  logic       freeze,
    input  logic [9:0] ball_y,
    output logic [9:0] p1_position,
    output logic [9:0] p2_position,
    output logic       move_tick
);

    localparam int CNT_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
    localparam logic signed [11:0] MIN_S  = $signed(12'(POS_MIN));
    localparam logic signed [11:0] MAX_S  = $signed(12'(POS_MAX));
    localparam logic signed [11:0] SLOW_S = $signed(12'(STEP_SLOW));
    localparam logic signed [11:0] FAST_S = $signed(12'(STEP_FAST));
    localparam logic [9:0]         INIT_P = 10'(POS_INIT);

    typedef enum logic [2:0] {IDLE, UP_SLOW, UP_FAST, DN_SLOW, DN_FAST} state_t;

    // ---------------- move tick ----------------
    logic [CNT_W-1:0] tick_cnt_reg;
    logic             move_tick_reg;
    logic             tick_edge;

    assign tick_edge = (tick_cnt_reg == CNT_LAST);
    assign move_tick = move_tick_reg;

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            tick_cnt_reg  <= '0;
            move_tick_reg <= 1'b0;
        end else begin
            tick_cnt_reg  <= tick_edge ? '0 : tick_cnt_reg + 1'b1;
            move_tick_reg <= tick_edge;
        end
    end

    // ---------------- button synchronizers ----------------
    logic [3:0] btn_raw;
    logic [3:0] sync1_reg;
    logic [3:0] sync2_reg;

    assign btn_raw = {p2_down, p2_up, p1_down, p1_up};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sync
            always_ff @(posedge sys_clk or negedge reset) begin
                if (!reset) begin
                    sync1_reg[gi] <= 1'b0;
                    sync2_reg[gi] <= 1'b0;
                end else begin
                    sync1_reg[gi] <= btn_raw[gi];
                    sync2_reg[gi] <= sync1_reg[gi];
                end
            end
        end
    endgenerate

    // ---------------- per-player direction requests ----------------
    logic [1:0]       up_req;
    logic [1:0]       dn_req;
    logic [1:0]       fast_en;
    logic [1:0][9:0]  pos_all;

    assign up_req[0] = sync2_reg[0];
    assign dn_req[0] = sync2_reg[1];

`ifdef PADDLE_AUTO_P2_EN
    logic [10:0] ball_ext;
    logic [10:0] p2_ext;
    logic [3:0]  unused_p2_btn;

    assign ball_ext      = {1'b0, ball_y};
    assign p2_ext        = {1'b0, pos_all[1]};
    // Compare with the offset on the other side so nothing can underflow.
    assign up_req[1]     = (ball_ext + 11'd8) < p2_ext;
    assign dn_req[1]     = ball_ext > (p2_ext + 11'd8);
    assign fast_en       = 2'b01;
    assign unused_p2_btn = {sync2_reg[3:2], sync1_reg[3:2]};
`else
    logic unused_ball_y;

    assign up_req[1]     = sync2_reg[2];
    assign dn_req[1]     = sync2_reg[3];
    assign fast_en       = 2'b11;
    assign unused_ball_y = ^ball_y;
`endif

    // ---------------- per-player FSM and position ----------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_player
            state_t              state_reg, state_next;
            logic [HOLD_W-1:0]   hold_reg, hold_next;
            logic [9:0]          pos_reg, pos_next;
            logic signed [11:0]  pos_calc;

            assign pos_all[gi] = pos_reg;

            always_ff @(posedge sys_clk or negedge reset) begin
                if (!reset) begin
                    state_reg <= IDLE;
                    hold_reg  <= '0;
                    pos_reg   <= INIT_P;
                end else begin
                    state_reg <= state_next;
                    hold_reg  <= hold_next;
                    pos_reg   <= pos_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                hold_next  = hold_reg;
                pos_next   = pos_reg;
                pos_calc   = $signed({2'b00, pos_reg});
                if (freeze) begin
                    state_next = IDLE;
                    hold_next  = '0;
                end else if (tick_edge) begin
                    if (up_req[gi] && !dn_req[gi]) begin
                        case (state_reg)
                            UP_SLOW: begin
                                if (hold_reg == HOLD_LAST && fast_en[gi]) begin
                                    state_next = UP_FAST;
                                end else begin
                                    state_next = UP_SLOW;
                                    if (hold_reg != HOLD_LAST) hold_next = hold_reg + 1'b1;
                                end
                            end
                            UP_FAST: state_next = UP_FAST;
                            default: begin
                                state_next = UP_SLOW;
                                hold_next  = '0;
                            end
                        endcase
                    end else if (dn_req[gi] && !up_req[gi]) begin
                        case (state_reg)
                            DN_SLOW: begin
                                if (hold_reg == HOLD_LAST && fast_en[gi]) begin
                                    state_next = DN_FAST;
                                end else begin
                                    state_next = DN_SLOW;
                                    if (hold_reg != HOLD_LAST) hold_next = hold_reg + 1'b1;
                                end
                            end
                            DN_FAST: state_next = DN_FAST;
                            default: begin
                                state_next = DN_SLOW;
                                hold_next  = '0;
                            end
                        endcase
                    end else begin
                        state_next = IDLE;
                        hold_next  = '0;
                    end

                    // Movement follows the state being entered, so the first press moves at once.
                    case (state_next)
                        UP_SLOW: pos_calc = $signed({2'b00, pos_reg}) - SLOW_S;
                        UP_FAST: pos_calc = $signed({2'b00, pos_reg}) - FAST_S;
                        DN_SLOW: pos_calc = $signed({2'b00, pos_reg}) + SLOW_S;
                        DN_FAST: pos_calc = $signed({2'b00, pos_reg}) + FAST_S;
                        default: pos_calc = $signed({2'b00, pos_reg});
                    endcase

                    if (pos_calc < MIN_S)      pos_next = MIN_S[9:0];
                    else if (pos_calc > MAX_S) pos_next = MAX_S[9:0];
                    else                       pos_next = pos_calc[9:0];
                end
            end
        end
    endgenerate

    assign p1_position = pos_all[0];
    assign p2_position = pos_all[1];

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl with TICK_DIV=4, HOLD_TICKS=3; expectations are hand-derived
// step/clamp sequences. Define PADDLE_AUTO_P2_EN to exercise ball tracking on paddle 2.
module tb_paddle_ctrl;

    logic       sys_clk = 1'b0;
    logic       reset   = 1'b0;
    logic       p1_up   = 1'b0;
    logic       p1_down = 1'b0;
    logic       p2_up   = 1'b0;
    logic       p2_down = 1'b0;
    logic       freeze  = 1'b0;
    logic [9:0] ball_y  = 10'd245;
    logic [9:0] p1_position;
    logic [9:0] p2_position;
    logic       move_tick;

    int tests = 0;
    int fails = 0;

    paddle_ctrl #(
        .TICK_DIV  (4),
        .POS_INIT  (245),
        .POS_MIN   (50),
        .POS_MAX   (430),
        .STEP_SLOW (2),
        .STEP_FAST (6),
        .HOLD_TICKS(3)
    ) dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .p1_up      (p1_up),
        .p1_down    (p1_down),
        .p2_up      (p2_up),
        .p2_down    (p2_down),
        .freeze     (freeze),
        .ball_y     (ball_y),
        .p1_position(p1_position),
        .p2_position(p2_position),
        .move_tick  (move_tick)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        $display("[TB] %s obs=%0d exp=%0d", tag, obs, exp);
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Returns on the falling edge just after a move_tick pulse (positions already updated).
    task automatic wait_tick(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (move_tick !== 1'b1 && n < 16);
        if (move_tick !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL %s: move_tick missing, got %b expected 1 within 16 cycles", tag, move_tick);
        end
    endtask

    initial begin
        int pulses;
        int last;
        int exp_p1;
        int exp_p2;
        int up_seq[6];

        up_seq = '{243, 241, 239, 233, 227, 221};

        // Reset values
        repeat (3) @(negedge sys_clk);
        check("rst_p1", p1_position, 245);
        check("rst_p2", p2_position, 245);
        check("rst_tick", move_tick, 0);
        reset = 1'b1;

        // Idle 20 cycles: tick every 4 cycles, first on cycle 4
        pulses = 0;
        last   = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge sys_clk);
            if (move_tick === 1'b1) begin
                pulses++;
                if (last == 0) check("first_tick", c, 4);
                else           check("tick_gap", c - last, 4);
                last = c;
            end
        end
        check("tick_count", pulses, 5);
        check("idle_p1", p1_position, 245);
        check("idle_p2", p2_position, 245);

        // Hold p1_up: three slow ticks then fast
        p1_up = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_tick("up_hold");
            check("up_hold_p1", p1_position, up_seq[i]);
            check("up_hold_p2", p2_position, 245);
        end

        // Async reset mid fast move
        reset = 1'b0;
        #1;
        check("async_rst_p1", p1_position, 245);
        check("async_rst_tick", move_tick, 0);
        p1_up = 1'b0;
        @(negedge sys_clk);
        reset = 1'b1;
        wait_tick("post_rst");
        check("post_rst_p1", p1_position, 245);

        // Hold p1_down to the bottom clamp
        p1_down = 1'b1;
        exp_p1  = 245;
        for (int i = 0; i < 36; i++) begin
            exp_p1 = exp_p1 + ((i < 3) ? 2 : 6);
            if (exp_p1 > 430) exp_p1 = 430;
            wait_tick("down_hold");
            check("down_hold_p1", p1_position, exp_p1);
        end

        // Reverse to 426, then down again into the clamp
        p1_down = 1'b0;
        p1_up   = 1'b1;
        wait_tick("rev_up");  check("rev_up_p1a", p1_position, 428);
        wait_tick("rev_up");  check("rev_up_p1b", p1_position, 426);
        p1_up = 1'b0;
        wait_tick("rel");     check("rel_p1", p1_position, 426);
        p1_down = 1'b1;
        wait_tick("dn426");   check("dn426_p1a", p1_position, 428);
        wait_tick("dn426");   check("dn426_p1b", p1_position, 430);
        wait_tick("dn426");   check("dn426_clamp", p1_position, 430);
        p1_down = 1'b0;
        wait_tick("rel2");    check("rel2_p1", p1_position, 430);
        p1_up = 1'b1;
        wait_tick("restart"); check("restart_slow_p1", p1_position, 428);
        p1_up = 1'b0;
        wait_tick("rel3");    check("rel3_p1", p1_position, 428);

`ifndef PADDLE_AUTO_P2_EN
        // Both p2 buttons together: no movement
        p2_up   = 1'b1;
        p2_down = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_tick("p2_both");
            check("p2_both_p2", p2_position, 245);
        end
        p2_up   = 1'b0;
        p2_down = 1'b0;
        wait_tick("p2_rel");  check("p2_rel_p2", p2_position, 245);
        // Simultaneous independent presses
        p1_up   = 1'b1;
        p2_down = 1'b1;
        wait_tick("simul");
        check("simul_p1", p1_position, 426);
        check("simul_p2", p2_position, 247);
        p2_down = 1'b0;
        exp_p2  = 247;
`else
        p1_up = 1'b1;
        wait_tick("simul");
        check("simul_p1", p1_position, 426);
        check("auto_idle_p2", p2_position, 245);
        exp_p2 = 245;
`endif

        // Freeze with p1_up still held
        freeze = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_tick("freeze");
            check("freeze_p1", p1_position, 426);
            check("freeze_p2", p2_position, exp_p2);
        end
        freeze = 1'b0;
        wait_tick("unfreeze"); check("unfreeze_p1a", p1_position, 424);
        wait_tick("unfreeze"); check("unfreeze_p1b", p1_position, 422);
        wait_tick("unfreeze"); check("unfreeze_p1c", p1_position, 420);
        wait_tick("unfreeze"); check("unfreeze_fast", p1_position, 414);
        p1_up = 1'b0;

`ifdef PADDLE_AUTO_P2_EN
        // Paddle 2 tracks the ball slowly until within 8 pixels
        reset = 1'b0;
        @(negedge sys_clk);
        ball_y = 10'd100;
        reset  = 1'b1;
        exp_p2 = 245;
        for (int i = 0; i < 80; i++) begin
            if (100 + 8 < exp_p2) exp_p2 = exp_p2 - 2;
            wait_tick("auto");
            check("auto_p2", p2_position, exp_p2);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
